// File: rtl/lbdr_input_fifo_if.sv
// Flit handshake bundle between an upstream link, the input FIFO and LBDR.
// Optional err_seq member follows LBDR_FIFO_SEQ_CHECK_EN.
interface lbdr_input_fifo_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] flit_in;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] flit_out;
  logic [2:0]            flit_id;
  logic [3:0]            dst_addr;
  logic                  empty;
  logic                  full;
  logic                  credit_out;
  logic                  overflow;
`ifdef LBDR_FIFO_SEQ_CHECK_EN
  logic                  err_seq;
`endif

  modport master (
`ifdef LBDR_FIFO_SEQ_CHECK_EN
    input  err_seq,
`endif
    output valid_in, flit_in, read_en,
    input  flit_out, flit_id, dst_addr, empty, full, credit_out, overflow
  );

  modport slave (
`ifdef LBDR_FIFO_SEQ_CHECK_EN
    output err_seq,
`endif
    input  valid_in, flit_in, read_en,
    output flit_out, flit_id, dst_addr, empty, full, credit_out, overflow
  );
endinterface

// File: rtl/lbdr_input_fifo.sv
// Router input buffer feeding LBDR: FWFT flit FIFO with credit return and sticky overflow.
// Define LBDR_FIFO_SEQ_CHECK_EN to add the HEADER/BODY/TAIL sequence checker (err_seq).
module lbdr_input_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PTR_W      = $clog2(DEPTH)
) (
  input logic              clk,
  input logic              rst,
  lbdr_input_fifo_if.slave bus
);

  localparam logic [PTR_W:0] PtrOne = (PTR_W + 1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
  logic                  credit_q, credit_d;
  logic                  overflow_q, overflow_d;
  logic                  empty, full, wr_en, rd_en;
  logic [DATA_WIDTH-1:0] head;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    wr_en      = bus.valid_in && !full;
    rd_en      = bus.read_en && !empty;
    wr_ptr_d   = wr_en ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d   = rd_en ? rd_ptr_q + PtrOne : rd_ptr_q;
    overflow_d = overflow_q || (bus.valid_in && full);
    credit_d   = rd_en;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= bus.flit_in;
    end
  end

  assign head           = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
  assign bus.flit_out   = head;
  assign bus.flit_id    = head[DATA_WIDTH-1 -: 3];
  assign bus.dst_addr   = head[3:0];
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.credit_out = credit_q;
  assign bus.overflow   = overflow_q;

`ifdef LBDR_FIFO_SEQ_CHECK_EN
  localparam logic [2:0] FlitHeader = 3'b001;
  localparam logic [2:0] FlitBody   = 3'b010;
  localparam logic [2:0] FlitTail   = 3'b100;

  typedef enum logic {StIdle, StInPkt} seq_state_e;

  seq_state_e state_q, state_d;
  logic       err_seq_q, err_seq_d;

  // Offending flits still move the FSM to the state their type implies.
  always_comb begin
    state_d   = state_q;
    err_seq_d = err_seq_q;
    if (wr_en) begin
      case (bus.flit_in[DATA_WIDTH-1 -: 3])
        FlitHeader: begin
          if (state_q == StInPkt) err_seq_d = 1'b1;
          state_d = StInPkt;
        end
        FlitBody: begin
          if (state_q == StIdle) err_seq_d = 1'b1;
        end
        FlitTail: begin
          if (state_q == StIdle) err_seq_d = 1'b1;
          state_d = StIdle;
        end
        default: err_seq_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      err_seq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_seq_q <= err_seq_d;
    end
  end

  assign bus.err_seq = err_seq_q;
`endif

endmodule

// File: tb/tb_lbdr_input_fifo.sv
// Scoreboard bench for lbdr_input_fifo: queue-based reference model, randomized traffic.
module tb_lbdr_input_fifo;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lbdr_input_fifo_if #(.DATA_WIDTH(DW)) bus ();

  lbdr_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: occupancy, flags, and expected flit order.
  logic [DW-1:0] exp_q[$];
  int  count      = 0;
  bit  ovf        = 0;
  bit  credit_nxt = 0;
  bit  in_pkt     = 0;
  bit  err        = 0;
  bit  known      = 0;

  // Expectations for the cycle currently on the bus.
  bit  exp_known = 0;
  bit  exp_empty, exp_full, exp_ovf, exp_credit, exp_err;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit v, input bit rd, input logic [DW-1:0] f);
    bit acc_wr, acc_rd;
    @(posedge clk);
    #1;
    exp_known  = known;
    exp_empty  = (count == 0);
    exp_full   = (count == DEPTH);
    exp_ovf    = ovf;
    exp_credit = credit_nxt;
    exp_err    = err;
    rst          = r;
    bus.valid_in = v;
    bus.flit_in  = f;
    bus.read_en  = rd && r;
    if (!r) begin
      count = 0; ovf = 0; credit_nxt = 0; in_pkt = 0; err = 0; known = 1;
      exp_q.delete();
    end else begin
      acc_wr = v && (count < DEPTH);
      acc_rd = rd && (count > 0);
      if (v && count == DEPTH) ovf = 1;
      if (acc_wr) begin
        exp_q.push_back(f);
        case (f[DW-1 -: 3])
          3'b001:  begin if (in_pkt) err = 1; in_pkt = 1; end
          3'b010:  begin if (!in_pkt) err = 1; end
          3'b100:  begin if (!in_pkt) err = 1; in_pkt = 0; end
          default: err = 1;
        endcase
      end
      count      = count + int'(acc_wr) - int'(acc_rd);
      credit_nxt = acc_rd;
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [2:0] id);
    logic [DW-1:0] f;
    f = $urandom();
    f[DW-1 -: 3] = id;
    return f;
  endfunction

  function automatic logic [2:0] rand_id();
    int unsigned p;
    p = $urandom_range(0, 9);
    if (p < 3) return 3'b001;
    if (p < 7) return 3'b010;
    if (p < 9) return 3'b100;
    return 3'($urandom_range(0, 7));
  endfunction

  // Monitor: compares flags every cycle, pops the scoreboard on each DUT pop.
  always @(negedge clk) begin
    if (exp_known) begin
      check("empty", DW'(bus.empty), DW'(exp_empty));
      check("full", DW'(bus.full), DW'(exp_full));
      check("overflow", DW'(bus.overflow), DW'(exp_ovf));
      check("credit_out", DW'(bus.credit_out), DW'(exp_credit));
`ifdef LBDR_FIFO_SEQ_CHECK_EN
      check("err_seq", DW'(bus.err_seq), DW'(exp_err));
`endif
      if (exp_empty) begin
        check("flit_out_zero", bus.flit_out, '0);
      end else if (rst) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_underflow: got flit %h expected none", bus.flit_out);
        end else begin
          check("flit_out", bus.flit_out, exp_q[0]);
          check("flit_id", DW'(bus.flit_id), DW'(exp_q[0][DW-1 -: 3]));
          check("dst_addr", DW'(bus.dst_addr), DW'(exp_q[0][3:0]));
          if (bus.read_en && !bus.empty) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.valid_in = 1'b0;
    bus.flit_in  = '0;
    bus.read_en  = 1'b0;
    drive(0, 0, 0, '0);
    drive(0, 0, 0, '0);
    // Single HEADER, one pop, credit pulse.
    drive(1, 1, 0, 32'h2000_0009);
    drive(1, 0, 1, '0);
    drive(1, 0, 0, '0);
    drive(1, 0, 0, '0);
    // Fill to full, overflow, then simultaneous read+write while full.
    for (int i = 0; i < 5; i++) drive(1, 1, 0, mk(rand_id()));
    drive(1, 1, 1, mk(3'b010));
    for (int i = 0; i < 5; i++) drive(1, 0, 1, '0);
    // Reset with three flits stored; read_en held while empty.
    drive(0, 0, 0, '0);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, mk(rand_id()));
    drive(0, 0, 0, '0);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, '0);
    // Ten-flit stream with continuous reads.
    for (int i = 0; i < 10; i++) drive(1, 1, i > 0, mk(rand_id()));
    drive(1, 0, 1, '0);
    drive(1, 0, 1, '0);
    // Well-formed packet, then BODY from idle; error must stay sticky.
    drive(0, 0, 0, '0);
    drive(1, 1, 1, mk(3'b001));
    drive(1, 1, 1, mk(3'b010));
    drive(1, 1, 1, mk(3'b100));
    drive(1, 1, 1, mk(3'b010));
    for (int i = 0; i < 4; i++) drive(1, 1, 1, mk(3'b001));
    // Randomized phases with varying write/read pressure and rare resets.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 250; i++) begin
        int unsigned wp, rp;
        wp = (ph == 0) ? 80 : (ph == 1) ? 30 : 55;
        rp = (ph == 0) ? 30 : (ph == 1) ? 80 : 55;
        drive(($urandom_range(0, 199) != 0),
              ($urandom_range(0, 99) < wp),
              ($urandom_range(0, 99) < rp),
              mk(rand_id()));
      end
    end
    for (int i = 0; i < 6; i++) drive(1, 0, 1, '0);
    drive(1, 0, 0, '0);
    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lbdr_input_fifo.md
Name: lbdr_input_fifo

Overview:
- Router input-port buffer directly upstream of the LBDR routing stage.
- Stores incoming flits in a first-word-fall-through FIFO.
- Presents the head flit's flit_id and dst_addr, plus the empty flag, to LBDR.
- Returns one credit per flit drained, for credit-based flow control with the upstream router.

Parameters:
- DATA_WIDTH, 32, flit width; bits [DATA_WIDTH-1:DATA_WIDTH-3] = flit_id, bits [3:0] = dst_addr (meaningful on HEADER only).
- DEPTH, 4, number of flit slots; power of two, >= 2.
- PTR_W, $clog2(DEPTH), pointer width; the internal pointers carry one extra wrap bit.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset).
- valid_in  input  1  upstream flit valid.
- flit_in  input  DATA_WIDTH  upstream flit.
- read_en  input  1  downstream (LBDR/crossbar) pops the head flit.
- flit_out  output  DATA_WIDTH  head flit (FWFT); all zeros when empty.
- flit_id  output  3  flit_out[DATA_WIDTH-1:DATA_WIDTH-3]; feeds LBDR flit_id.
- dst_addr  output  4  flit_out[3:0]; feeds LBDR dst_addr.
- empty  output  1  FIFO holds no flit; feeds LBDR empty.
- full  output  1  FIFO holds DEPTH flits.
- credit_out  output  1  one-cycle pulse per flit popped.
- overflow  output  1  sticky flag: a write was attempted while full.

Behaviour:
- Flit encodings (include/parameters.sv): HEADER = 3'b001, BODY = 3'b010, TAIL = 3'b100.
- Reset (rst == 0 at a clock edge):
  - wr_ptr = 0, rd_ptr = 0.
  - empty = 1, full = 0, credit_out = 0, overflow = 0.
  - Memory contents are don't-care.
  - Reset mid-packet discards all stored flits and sends no credits for them.
- Write: flit_in is stored at mem[wr_ptr] and wr_ptr increments when valid_in = 1 and full = 0 (full sampled before the edge).
- Overflow: valid_in = 1 with full = 1 drops the flit, sets overflow = 1, and leaves pointers unchanged. overflow clears only on reset.
- Read: rd_ptr increments when read_en = 1 and empty = 0. read_en while empty is ignored and produces no credit.
- Simultaneous read and write:
  - Not empty and not full: both occur and occupancy is unchanged.
  - Full: only the read occurs (no pass-through); the write is dropped and overflow is set.
  - Empty: only the write occurs.
- Latency: a flit written at edge N appears on flit_out and deasserts empty after edge N (visible in cycle N+1). No combinational path from flit_in to flit_out.
- Flags:
  - empty = (wr_ptr == rd_ptr).
  - full = (MSBs differ) and (low PTR_W bits equal).
  - Pointers wrap modulo 2*DEPTH.
- credit_out: registered; equals 1 in the cycle after each accepted read, 0 otherwise.
- flit_out, flit_id, dst_addr: combinational from mem[rd_ptr[PTR_W-1:0]], gated to zero when empty.

Optional Feature:
- Macro: LBDR_FIFO_SEQ_CHECK_EN.
- When defined:
  - Adds output err_seq (1 bit, sticky, reset 0) and a 2-state write-side FSM.
  - States: IDLE (reset state) and IN_PKT.
  - IDLE: accepted HEADER -> IN_PKT.
  - IN_PKT: accepted TAIL -> IDLE; accepted BODY stays in IN_PKT.
  - err_seq sets on an accepted BODY or TAIL in IDLE, an accepted HEADER in IN_PKT, or any other flit_id value.
  - Offending flits are still stored; the FSM takes the state implied by the flit (HEADER -> IN_PKT, TAIL -> IDLE).
- When undefined: no err_seq port and no FSM logic.

Test Plan:
- Reset, then write HEADER 32'h2000_0009 -> the next cycle shows empty = 0, flit_id = 3'b001, dst_addr = 4'h9; read_en pulse -> credit_out = 1 for one cycle, then empty = 1.
- Write 4 flits with no reads (DEPTH = 4) -> full = 1 after the 4th; a 5th write sets overflow = 1, and the drained data equals the first 4 flits in order.
- Full FIFO with valid_in = 1 and read_en = 1 in the same cycle -> one flit popped, new flit dropped, full = 0, overflow = 1.
- Stream 10 flits with continuous reads -> pointers wrap, output order matches input order, 10 credit pulses, overflow = 0.
- read_en held with the FIFO empty -> no credit_out, pointers unchanged. Asserting rst = 0 with 3 flits stored -> empty = 1 and no credits sent.
- With LBDR_FIFO_SEQ_CHECK_EN: HEADER, BODY, TAIL -> err_seq = 0. Then BODY from IDLE -> err_seq = 1, and it remains 1 until reset.
